// File: rtl/pmp_pkg.sv
// Shared definitions for the pattern-matching engine: command opcodes,
// control-word field positions and the handshake state encoding.
package pmp_pkg;

    localparam int PAT_BYTES = 8;
    localparam int CTRL_W    = 16;
    localparam int DATA_W    = 8 * PAT_BYTES;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 14;
    localparam int NB_HI    = 13;
    localparam int NB_LO    = 11;
    localparam int LAST_BIT = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pmp_byte_window.sv
// Sliding window of the most recent stream bytes plus a fill counter, with a
// comparator that reports a pattern hit on the window as it will be after this shift.
module pmp_byte_window
    import pmp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shiftEn,
    input  logic [7:0]        byteIn,
    input  logic              clear,
    input  logic [DATA_W-1:0] pattern,
    input  logic [3:0]        plen,
    output logic              hit
);

    // The oldest byte falls out on the next shift, so only seven bytes are stored.
    logic [DATA_W-9:0] hist_q, hist_d;
    logic [3:0]        seen_q, seen_d;
    logic [DATA_W-1:0] histNext;
    logic [3:0]        seenNext;
    logic [2:0]        pIdx;

    always_comb begin
        histNext = {hist_q, byteIn};
        seenNext = (seen_q == 4'(PAT_BYTES)) ? seen_q : seen_q + 4'd1;
        hist_d   = hist_q;
        seen_d   = seen_q;
        if (clear) begin
            hist_d = '0;
            seen_d = '0;
        end else if (shiftEn) begin
            hist_d = histNext[DATA_W-9:0];
            seen_d = seenNext;
        end
    end

    // Newest window byte pairs with the last pattern byte, and so on backwards.
    always_comb begin
        pIdx = '0;
        hit  = shiftEn && (plen != 4'd0) && (seenNext >= plen);
        for (int i = 0; i < PAT_BYTES; i++) begin
            if (4'(i) < plen) begin
                pIdx = 3'(plen - 4'd1 - 4'(i));
                if (histNext[i*8 +: 8] != pattern[{pIdx, 3'b000} +: 8]) begin
                    hit = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/pmp_match_unit.sv
// Byte-serial pattern matcher: latches one command per 4-phase handshake,
// scans MATCH chunks one byte per cycle and keeps a sticky match flag.
module pmp_match_unit
    import pmp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [CTRL_W-1:0] control,
    input  logic              data_ready,
    output logic              data_accepted,
    output logic              pattern_accepted
);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] chunk_q, chunk_d;
    logic [2:0]        nbm1_q, nbm1_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [3:0]        plen_q, plen_d;
    logic              flag_q, flag_d;

    logic [1:0] opcode;
    logic       accept;
    logic       winShift;
    logic       winClear;
    logic [7:0] winByte;
    logic       winHit;
    logic       unusedCtrl;

    assign opcode        = control[OPC_HI:OPC_LO];
    assign unusedCtrl    = ^control[LAST_BIT-1:0];
    assign data_accepted = (state_q == ST_DONE);
    assign pattern_accepted = flag_q;
    assign accept = (state_q == ST_IDLE) && data_ready && !data_accepted && (opcode != OP_NOP);

    pmp_byte_window u_window (
        .clk     (clk),
        .reset   (reset),
        .shiftEn (winShift),
        .byteIn  (winByte),
        .clear   (winClear),
        .pattern (pattern_q),
        .plen    (plen_q),
        .hit     (winHit)
    );

    // A LAST chunk wipes the window on its final byte; that byte's hit still counts.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chunk_d   = chunk_q;
        nbm1_d    = nbm1_q;
        last_d    = last_q;
        pattern_d = pattern_q;
        plen_d    = plen_q;
        flag_d    = flag_q;
        winShift  = 1'b0;
        winClear  = 1'b0;
        winByte   = chunk_q[{idx_q, 3'b000} +: 8];
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_LOAD: begin
                            pattern_d = data;
                            plen_d    = {1'b0, control[NB_HI:NB_LO]} + 4'd1;
                            flag_d    = 1'b0;
                            winClear  = 1'b1;
                            state_d   = ST_DONE;
                        end
                        OP_CLEAR: begin
                            flag_d   = 1'b0;
                            winClear = 1'b1;
                            state_d  = ST_DONE;
                        end
                        OP_MATCH: begin
                            chunk_d = data;
                            nbm1_d  = control[NB_HI:NB_LO];
                            last_d  = control[LAST_BIT];
                            idx_d   = 3'd0;
                            state_d = ST_SCAN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SCAN: begin
                winShift = 1'b1;
                if (winHit) begin
                    flag_d = 1'b1;
                end
                if (idx_q == nbm1_q) begin
                    winClear = last_q;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (!data_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            chunk_q   <= '0;
            nbm1_q    <= '0;
            last_q    <= 1'b0;
            pattern_q <= '0;
            plen_q    <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chunk_q   <= chunk_d;
            nbm1_q    <= nbm1_d;
            last_q    <= last_d;
            pattern_q <= pattern_d;
            plen_q    <= plen_d;
            flag_q    <= flag_d;
        end
    end

endmodule
